// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with CDB capture, commit, forwarding and mispredict flush
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueValid,
  input  logic                 issueHasDest,
  input  logic [4:0]           issueDest,
  output logic [ROB_WIDTH-1:0] issueRobId,
  output logic                 robFull,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [31:0]          cdbValue,
  input  logic                 cdbMispredict,
  input  logic [31:0]          cdbNewPc,
  input  logic [ROB_WIDTH-1:0] robRs1Dep,
  output logic                 robRs1Ready,
  output logic [31:0]          robRs1Value,
  input  logic [ROB_WIDTH-1:0] robRs2Dep,
  output logic                 robRs2Ready,
  output logic [31:0]          robRs2Value,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  output logic                 clearOut,
  output logic [31:0]          newPcOut
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH+1)'(DEPTH);

  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count;
  logic [DEPTH-1:0]     busy, ready, has_dest, mispredict;
  logic [4:0]           dest   [DEPTH];
  logic [31:0]          value  [DEPTH];
  logic [31:0]          new_pc [DEPTH];

  logic issue_fire, cdb_fire, commit_fire, flush;

  assign robFull     = (count == FULL_COUNT);
  assign issueRobId  = tail;
  assign issue_fire  = issueValid && !robFull && readyIn;
  assign cdb_fire    = cdbValid && readyIn && busy[cdbRobId];
  assign commit_fire = readyIn && (count != '0) && ready[head];
  assign flush       = commit_fire && mispredict[head];

  // Same-cycle CDB results bypass the entry array so dependents see them immediately.
  assign robRs1Ready = ready[robRs1Dep] || (cdbValid && cdbRobId == robRs1Dep);
  assign robRs1Value = (cdbValid && cdbRobId == robRs1Dep) ? cdbValue : value[robRs1Dep];
  assign robRs2Ready = ready[robRs2Dep] || (cdbValid && cdbRobId == robRs2Dep);
  assign robRs2Value = (cdbValid && cdbRobId == robRs2Dep) ? cdbValue : value[robRs2Dep];

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      regUpdateValid <= 1'b0;
      regUpdateDest  <= '0;
      regUpdateValue <= '0;
      regUpdateRobId <= '0;
      clearOut       <= 1'b0;
      newPcOut       <= '0;
    end else begin
      regUpdateValid <= 1'b0;
      regUpdateDest  <= '0;
      regUpdateValue <= '0;
      regUpdateRobId <= '0;
      clearOut       <= 1'b0;
      newPcOut       <= '0;
      if (commit_fire) begin
        regUpdateValid <= 1'b1;
        regUpdateDest  <= has_dest[head] ? dest[head] : 5'd0;
        regUpdateValue <= value[head];
        regUpdateRobId <= head;
        busy[head]     <= 1'b0;
        head           <= head + 1'b1;
      end
      if (flush) begin
        // The branch's own link write still goes out; everything younger is dropped.
        clearOut <= 1'b1;
        newPcOut <= new_pc[head];
        busy     <= '0;
        ready    <= '0;
        tail     <= head + 1'b1;
        count    <= '0;
      end else begin
        if (cdb_fire)
          ready[cdbRobId] <= 1'b1;
        if (issue_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + 1'b1;
        end
        case ({issue_fire, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clockIn) begin
    if (!flush) begin
      if (issue_fire) begin
        has_dest[tail]   <= issueHasDest;
        dest[tail]       <= issueDest;
        mispredict[tail] <= 1'b0;
      end
      if (cdb_fire) begin
        value[cdbRobId]      <= cdbValue;
        mispredict[cdbRobId] <= cdbMispredict;
        new_pc[cdbRobId]     <= cdbNewPc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - randomized and directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  localparam int W = 4;
  localparam int DEPTH = 1 << W;

  logic         clockIn = 1'b0;
  logic         resetIn, readyIn, issueValid, issueHasDest;
  logic [4:0]   issueDest;
  logic [W-1:0] issueRobId;
  logic         robFull;
  logic         cdbValid, cdbMispredict;
  logic [W-1:0] cdbRobId;
  logic [31:0]  cdbValue, cdbNewPc;
  logic [W-1:0] robRs1Dep, robRs2Dep;
  logic         robRs1Ready, robRs2Ready;
  logic [31:0]  robRs1Value, robRs2Value;
  logic         regUpdateValid;
  logic [4:0]   regUpdateDest;
  logic [31:0]  regUpdateValue;
  logic [W-1:0] regUpdateRobId;
  logic         clearOut;
  logic [31:0]  newPcOut;

  always #5 clockIn = ~clockIn;

  reorder_buffer #(.ROB_WIDTH(W)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
    .issueValid(issueValid), .issueHasDest(issueHasDest), .issueDest(issueDest),
    .issueRobId(issueRobId), .robFull(robFull),
    .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue),
    .cdbMispredict(cdbMispredict), .cdbNewPc(cdbNewPc),
    .robRs1Dep(robRs1Dep), .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
    .robRs2Dep(robRs2Dep), .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value),
    .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
    .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
    .clearOut(clearOut), .newPcOut(newPcOut)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: program-order queue of live ids plus per-id result slots.
  int          q[$];
  int          next_id;
  bit          m_busy[DEPTH], m_ready[DEPTH], m_hd[DEPTH], m_mp[DEPTH];
  logic [4:0]  m_dest[DEPTH];
  logic [31:0] m_value[DEPTH], m_pc[DEPTH];
  bit          e_valid, e_clear;
  logic [4:0]  e_dest;
  logic [31:0] e_value, e_pc;
  int          e_id;

  task automatic model_reset();
    q.delete();
    next_id = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i]  = 1'b0;
      m_ready[i] = 1'b0;
      m_mp[i]    = 1'b0;
    end
    e_valid = 1'b0;
    e_clear = 1'b0;
  endtask

  task automatic model_edge();
    bit commit, flush, full;
    int h;
    h = 0;
    flush = 1'b0;
    full = (q.size() == DEPTH);
    commit = readyIn && q.size() > 0 && m_ready[q[0]];
    e_valid = commit;
    e_clear = 1'b0;
    if (commit) begin
      h       = q[0];
      flush   = m_mp[h];
      e_dest  = m_hd[h] ? m_dest[h] : 5'd0;
      e_value = m_value[h];
      e_id    = h;
      e_clear = flush;
      e_pc    = m_pc[h];
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_busy[i]  = 1'b0;
        m_ready[i] = 1'b0;
      end
      q.delete();
      next_id = (h + 1) % DEPTH;
    end else begin
      if (readyIn && cdbValid && m_busy[cdbRobId]) begin
        m_ready[cdbRobId] = 1'b1;
        m_value[cdbRobId] = cdbValue;
        m_mp[cdbRobId]    = cdbMispredict;
        m_pc[cdbRobId]    = cdbNewPc;
      end
      if (commit) begin
        void'(q.pop_front());
        m_busy[h] = 1'b0;
      end
      if (issueValid && readyIn && !full) begin
        q.push_back(next_id);
        m_busy[next_id]  = 1'b1;
        m_ready[next_id] = 1'b0;
        m_mp[next_id]    = 1'b0;
        m_hd[next_id]    = issueHasDest;
        m_dest[next_id]  = issueDest;
        next_id = (next_id + 1) % DEPTH;
      end
    end
  endtask

  task automatic check_lookup(input string tag, input int dep, input logic rdy, input logic [31:0] val);
    bit hit;
    hit = cdbValid && (int'(cdbRobId) == dep);
    check_eq({tag, "_ready"}, rdy, m_ready[dep] || hit);
    if (m_ready[dep] || hit)
      check_eq({tag, "_value"}, val, hit ? cdbValue : m_value[dep]);
  endtask

  task automatic step();
    #2;
    check_eq("rob_full", robFull, q.size() == DEPTH);
    check_eq("issue_id", issueRobId, next_id);
    check_lookup("rs1", robRs1Dep, robRs1Ready, robRs1Value);
    check_lookup("rs2", robRs2Dep, robRs2Ready, robRs2Value);
    @(posedge clockIn);
    model_edge();
    #1;
    check_eq("upd_valid", regUpdateValid, e_valid);
    check_eq("clear", clearOut, e_clear);
    if (e_valid) begin
      check_eq("upd_dest", regUpdateDest, e_dest);
      check_eq("upd_value", regUpdateValue, e_value);
      check_eq("upd_id", regUpdateRobId, e_id);
    end
    if (e_clear)
      check_eq("new_pc", newPcOut, e_pc);
  endtask

  task automatic idle();
    readyIn = 1'b1;
    issueValid = 1'b0; issueHasDest = 1'b0; issueDest = '0;
    cdbValid = 1'b0; cdbRobId = '0; cdbValue = '0; cdbMispredict = 1'b0; cdbNewPc = '0;
    robRs1Dep = '0; robRs2Dep = '0;
  endtask

  task automatic issue_one(input logic [4:0] d);
    idle();
    issueValid = 1'b1; issueHasDest = 1'b1; issueDest = d;
    step();
  endtask

  task automatic cdb_one(input int id, input logic [31:0] val, input logic mp, input logic [31:0] pc);
    idle();
    cdbValid = 1'b1; cdbRobId = W'(id); cdbValue = val; cdbMispredict = mp; cdbNewPc = pc;
    step();
  endtask

  task automatic do_reset();
    idle();
    resetIn = 1'b0;
    #1;
    check_eq("rst_upd_valid", regUpdateValid, 0);
    check_eq("rst_clear", clearOut, 0);
    check_eq("rst_full", robFull, 0);
    check_eq("rst_issue_id", issueRobId, 0);
    model_reset();
    @(negedge clockIn);
    resetIn = 1'b1;
    @(posedge clockIn);
    #1;
  endtask

  initial begin
    resetIn = 1'b1;
    idle();
    #2;
    do_reset();

    // in-order commit with out-of-order completion
    issue_one(5'd5); issue_one(5'd6); issue_one(5'd7);
    cdb_one(2, 32'd33, 1'b0, 0);
    cdb_one(0, 32'd11, 1'b0, 0);
    cdb_one(1, 32'd22, 1'b0, 0);
    check_eq("ino_dest0", regUpdateDest, 5); check_eq("ino_val0", regUpdateValue, 11);
    check_eq("ino_id0", regUpdateRobId, 0);
    idle(); step();
    check_eq("ino_dest1", regUpdateDest, 6); check_eq("ino_val1", regUpdateValue, 22);
    check_eq("ino_id1", regUpdateRobId, 1);
    idle(); step();
    check_eq("ino_dest2", regUpdateDest, 7); check_eq("ino_val2", regUpdateValue, 33);
    check_eq("ino_id2", regUpdateRobId, 2);

    // full and wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue_one(5'(i + 1));
    check_eq("full_flag", robFull, 1);
    issue_one(5'd31);
    check_eq("full_ignored_id", issueRobId, 0);
    cdb_one(0, 32'h77, 1'b0, 0);
    idle(); step();
    check_eq("wrap_commit", regUpdateValid, 1);
    check_eq("wrap_not_full", robFull, 0);
    check_eq("wrap_id", issueRobId, 0);
    issue_one(5'd9);
    check_eq("wrap_full_again", robFull, 1);

    // same-cycle forwarding
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(5'(i + 1));
    idle();
    robRs1Dep = W'(3); robRs2Dep = W'(2);
    cdbValid = 1'b1; cdbRobId = W'(3); cdbValue = 32'hDEAD;
    #1;
    check_eq("fwd_ready", robRs1Ready, 1);
    check_eq("fwd_value", robRs1Value, 32'hDEAD);
    check_eq("fwd_other_not_ready", robRs2Ready, 0);
    step();

    // mispredict flush
    do_reset();
    for (int i = 0; i < 5; i++) issue_one(5'(i + 1));
    cdb_one(0, 32'd1, 1'b0, 0);
    cdb_one(1, 32'h44, 1'b1, 32'h100);
    idle(); step();
    check_eq("mp_clear", clearOut, 1);
    check_eq("mp_pc", newPcOut, 32'h100);
    check_eq("mp_link", regUpdateValue, 32'h44);
    check_eq("mp_next_id", issueRobId, 2);
    cdb_one(3, 32'd5, 1'b0, 0);
    idle(); step();
    check_eq("mp_no_commit", regUpdateValid, 0);

    // stall with a ready head
    do_reset();
    issue_one(5'd3);
    cdb_one(0, 32'h55, 1'b0, 0);
    idle(); readyIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_no_commit", regUpdateValid, 0);
    end
    idle(); step();
    check_eq("stall_commit", regUpdateValid, 1);
    check_eq("stall_value", regUpdateValue, 32'h55);

    // randomized traffic with a mid-run reset
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      readyIn       = ($urandom_range(0, 9) != 0);
      issueValid    = $urandom_range(0, 1) != 0;
      issueHasDest  = $urandom_range(0, 3) != 0;
      issueDest     = 5'($urandom);
      cdbValid      = $urandom_range(0, 2) != 0;
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        cdbRobId = W'(q[$urandom_range(0, q.size() - 1)]);
      else
        cdbRobId = W'($urandom);
      cdbValue      = $urandom;
      cdbMispredict = ($urandom_range(0, 15) == 0);
      cdbNewPc      = $urandom;
      robRs1Dep     = W'($urandom);
      robRs2Dep     = W'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
